// File: rtl/entrada_decimal.sv
// Decimal keypad entry for the IN instruction: debounces two keys, accumulates up to
// MAX_DIGITS BCD digits from the switches and hands the value over with a ready flag.
module entrada_decimal #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_DIGITS      = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  chaves,
  input  logic        botaoDigito,
  input  logic        botaoOk,
  input  logic        controleIN,
  output logic        dadoPronto,
  output logic [31:0] dado,
  output logic [31:0] eco,
  output logic        erro
);

  localparam int ACC_W = 17;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MAX_DIGITS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  // Key index 0 is the digit key, index 1 the OK key
  logic [1:0]       raw_keys;
  logic [1:0]       sync_a;
  logic [1:0]       sync_b;
  logic [1:0]       level;
  logic [1:0]       level_prev;
  logic [1:0]       press;
  logic [DEB_W-1:0] deb_cnt [2];

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] acc_x10;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             erro_next;
  logic             commit;

  logic             pronto_q;
  logic [ACC_W-1:0] dado_q;
  logic [ACC_W-1:0] eco_q;
  logic             erro_q;

  logic             digit_press;
  logic             ok_press;

  assign raw_keys    = {botaoOk, botaoDigito};
  assign digit_press = press[0];
  assign ok_press    = press[1];

  // The accepted level only follows the synchronized key after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a     <= 2'b11;
      sync_b     <= 2'b11;
      level      <= 2'b11;
      level_prev <= 2'b11;
      press      <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        deb_cnt[k] <= '0;
      end
    end else begin
      sync_a     <= raw_keys;
      sync_b     <= sync_a;
      level_prev <= level;
      press      <= level_prev & ~level;
      for (int k = 0; k < 2; k++) begin
        if (sync_b[k] == level[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DEB_LAST) begin
          level[k]   <= sync_b[k];
          deb_cnt[k] <= '0;
        end else begin
          deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign acc_x10 = {acc[ACC_W-4:0], 3'b000} + {acc[ACC_W-2:0], 1'b0};

  // A digit is applied before a simultaneous OK, so the commit sees acc_next
  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;
    erro_next  = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (controleIN) begin
          state_next = S_COLLECT;
          acc_next   = '0;
          count_next = '0;
        end
      end
      S_COLLECT: begin
        if (!controleIN) begin
          state_next = S_IDLE;
        end else begin
          if (digit_press) begin
            if (chaves > 4'd9 || count == MAX_COUNT) begin
              erro_next = 1'b1;
            end else begin
              acc_next   = acc_x10 + {{(ACC_W-4){1'b0}}, chaves};
              count_next = count + 1'b1;
            end
          end
          if (ok_press) begin
            commit     = 1'b1;
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!controleIN) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      acc      <= '0;
      count    <= '0;
      erro_q   <= 1'b0;
      pronto_q <= 1'b0;
      dado_q   <= '0;
      eco_q    <= '0;
    end else begin
      state  <= state_next;
      acc    <= acc_next;
      count  <= count_next;
      erro_q <= erro_next;
      eco_q  <= (state_next == S_IDLE) ? '0 : acc_next;
      if (commit) begin
        dado_q   <= acc_next;
        pronto_q <= 1'b1;
      end else if (state == S_DONE && !controleIN) begin
        pronto_q <= 1'b0;
      end
    end
  end

  assign dadoPronto = pronto_q;
  assign dado       = {{(32-ACC_W){1'b0}}, dado_q};
  assign eco        = {{(32-ACC_W){1'b0}}, eco_q};
  assign erro       = erro_q;

endmodule
